// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and count-mode constants for the gray counter
// and any CDC receiver that needs to decode a sampled Gray pointer.
package gray_pkg;

  // Widest counter the helpers cover; callers size-cast to their own width.
  localparam int MAX_WIDTH = 32;

  typedef logic [MAX_WIDTH-1:0] word_t;

  // Values for the WRAP parameter of gray_counter.
  localparam int WRAP_MODE = 1;
  localparam int SAT_MODE  = 0;

  // Binary to Gray: each Gray bit is the XOR of two adjacent binary bits.
  function automatic word_t bin2gray(input word_t bv);
    return bv ^ (bv >> 1);
  endfunction

  // Gray to binary: prefix XOR running down from the MSB.
  // Zero-extended upper bits contribute nothing, so any width up to MAX_WIDTH works.
  function automatic word_t gray2bin(input word_t gv);
    word_t bv;
    bv[MAX_WIDTH-1] = gv[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      bv[i] = bv[i+1] ^ gv[i];
    end
    return bv;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary decoder. Used on the counter's load path and
// reusable by a receiving clock domain to decode a synchronised Gray pointer.
module gray2bin_conv
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Widen to the package word, decode, then trim back to our width.
  assign bin = WIDTH'(gray2bin(word_t'(gray)));

endmodule

// File: rtl/gray_counter.sv
// Registered up/down Gray-code counter with a parallel binary view.
// Supports synchronous load in binary or Gray form and either wraps or
// saturates at the range ends. The Gray output comes straight from a flop so
// it can be sampled safely by another clock domain.
module gray_counter
  import gray_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter int               WRAP      = WRAP_MODE,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic             load_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] b,
  output logic             tc,
  output logic             wrap,
  output logic             sat
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] ZERO    = '0;
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH - 1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] RST_G   = WIDTH'(bin2gray(word_t'(RESET_VAL)));

  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] b_next;
  logic [WIDTH-1:0] g_next;
  logic             wrap_next;
  logic             sat_next;

  // Decode a Gray-coded load value; only used when load_gray is set.
  gray2bin_conv #(
    .WIDTH(WIDTH)
  ) u_load_dec (
    .gray(load_val),
    .bin (load_bin)
  );

  // Terminal count follows the live direction input, not a registered copy.
  assign tc = (up && (b == MAX_VAL)) || (!up && (b == ZERO));

  // Next-state selection: load beats counting; at the range end either wrap or hold.
  always_comb begin
    b_next    = b;
    wrap_next = 1'b0;
    sat_next  = 1'b0;
    if (load) begin
      b_next = load_gray ? load_bin : load_val;
    end else if (en) begin
      if (!tc) begin
        b_next = up ? (b + ONE) : (b - ONE);
      end else if (WRAP == WRAP_MODE) begin
        b_next    = up ? ZERO : MAX_VAL;
        wrap_next = 1'b1;
      end else begin
        sat_next = 1'b1;
      end
    end
  end

  // Gray image of the next binary value, so g and b land on the same edge.
  always_comb begin
    g_next = WIDTH'(bin2gray(word_t'(b_next)));
  end

  // State and flag registers; reset acts immediately without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b    <= RESET_VAL;
      g    <= RST_G;
      wrap <= 1'b0;
      sat  <= 1'b0;
    end else begin
      b    <= b_next;
      g    <= g_next;
      wrap <= wrap_next;
      sat  <= sat_next;
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter: one wrapping and one saturating instance
// share the same stimulus, each checked against hand-computed values.
module tb_gray_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up;
  logic       load;
  logic       load_gray;
  logic [3:0] load_val;

  logic [3:0] g_w, b_w, g_s, b_s;
  logic       tc_w, wrap_w, sat_w;
  logic       tc_s, wrap_s, sat_s;

  int compared;
  int mismatched;

  typedef struct {
    logic       en;
    logic       up;
    logic       load;
    logic       lg;
    logic [3:0] lv;
    logic       tcw;
    logic       tcs;
    logic [3:0] bw;
    logic [3:0] gw;
    logic       wrw;
    logic [3:0] bs;
    logic [3:0] gs;
    logic       sts;
  } vec_t;

  vec_t vecs [14];

  gray_counter #(
    .WIDTH(4),
    .WRAP(1),
    .RESET_VAL(4'd0)
  ) dut_wrap (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .up(up),
    .load(load),
    .load_gray(load_gray),
    .load_val(load_val),
    .g(g_w),
    .b(b_w),
    .tc(tc_w),
    .wrap(wrap_w),
    .sat(sat_w)
  );

  gray_counter #(
    .WIDTH(4),
    .WRAP(0),
    .RESET_VAL(4'd0)
  ) dut_sat (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .up(up),
    .load(load),
    .load_gray(load_gray),
    .load_val(load_val),
    .g(g_s),
    .b(b_s),
    .tc(tc_s),
    .wrap(wrap_s),
    .sat(sat_s)
  );

  // 10-unit clock period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag,
                          input logic [3:0] bw, input logic [3:0] gw, input logic wrw,
                          input logic [3:0] bs, input logic [3:0] gs, input logic sts);
    checkOutput({tag, " b_w"}, 32'(b_w), 32'(bw));
    checkOutput({tag, " g_w"}, 32'(g_w), 32'(gw));
    checkOutput({tag, " wrap_w"}, 32'(wrap_w), 32'(wrw));
    checkOutput({tag, " sat_w"}, 32'(sat_w), 32'd0);
    checkOutput({tag, " b_s"}, 32'(b_s), 32'(bs));
    checkOutput({tag, " g_s"}, 32'(g_s), 32'(gs));
    checkOutput({tag, " wrap_s"}, 32'(wrap_s), 32'd0);
    checkOutput({tag, " sat_s"}, 32'(sat_s), 32'(sts));
  endtask

  // Drive one vector after the falling edge, check tc before the rising edge,
  // then check registered outputs just after it.
  task automatic applyStimulus(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    en        = v.en;
    up        = v.up;
    load      = v.load;
    load_gray = v.lg;
    load_val  = v.lv;
    #1;
    checkOutput({tag, " tc_w"}, 32'(tc_w), 32'(v.tcw));
    checkOutput({tag, " tc_s"}, 32'(tc_s), 32'(v.tcs));
    @(posedge clk);
    #1;
    checkAll(tag, v.bw, v.gw, v.wrw, v.bs, v.gs, v.sts);
  endtask

  initial begin
    logic [3:0] k4;
    logic [3:0] kg;
    logic [3:0] prev_g;

    compared   = 0;
    mismatched = 0;

    //          en    up    load  lg    lv        tcw   tcs   bw     gw       wrw   bs     gs       sts
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'b1101, 1'b0, 1'b1, 4'd9,  4'b1101, 1'b0, 4'd9,  4'b1101, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b1001, 1'b0, 1'b0, 4'd9,  4'b1101, 1'b0, 4'd9,  4'b1101, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'd0,  4'b0000, 1'b0, 4'd0,  4'b0000, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 4'd15, 4'b1000, 1'b1, 4'd0,  4'b0000, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'd14, 4'b1001, 1'b0, 4'd0,  4'b0000, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'd13, 4'b1011, 1'b0, 4'd0,  4'b0000, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'd14, 4'b1001, 1'b0, 4'd1,  4'b0001, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b0011, 1'b0, 1'b0, 4'd3,  4'b0010, 1'b0, 4'd3,  4'b0010, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'b0111, 1'b0, 1'b0, 4'd7,  4'b0100, 1'b0, 4'd7,  4'b0100, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 4'd15, 4'b1000, 1'b0, 4'd15, 4'b1000, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b1, 4'd15, 4'b1000, 1'b0, 4'd15, 4'b1000, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 4'd15, 4'b1000, 1'b0, 4'd15, 4'b1000, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 4'd0,  4'b0000, 1'b1, 4'd15, 4'b1000, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'd0,  4'b0000, 1'b0, 4'd15, 4'b1000, 1'b0};

    rst_n     = 1'b0;
    en        = 1'b0;
    up        = 1'b1;
    load      = 1'b0;
    load_gray = 1'b0;
    load_val  = 4'd0;

    // Reset values appear before any clock edge.
    #2;
    checkAll("reset", 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    up    = 1'b1;

    // Count up through the whole range; the wrap instance rolls over, the other sticks.
    prev_g = 4'd0;
    for (int k = 1; k <= 16; k++) begin
      #1;
      checkOutput($sformatf("up%0d tc_w", k), 32'(tc_w), (k == 16) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
      k4 = k[3:0];
      kg = k4 ^ (k4 >> 1);
      if (k == 16) begin
        checkAll("up16", 4'd0, 4'b0000, 1'b1, 4'd15, 4'b1000, 1'b1);
      end else begin
        checkAll($sformatf("up%0d", k), k4, kg, 1'b0, k4, kg, 1'b0);
      end
      checkOutput($sformatf("up%0d onebit", k), 32'($countones(g_w ^ prev_g)), 32'd1);
      prev_g = g_w;
      @(negedge clk);
    end

    for (int i = 0; i < 14; i++) begin
      applyStimulus(i, vecs[i]);
    end

    // tc follows the live up input without a clock edge (wrap instance sits at 0).
    @(negedge clk);
    en   = 1'b0;
    load = 1'b0;
    up   = 1'b0;
    #1;
    checkOutput("live tc down", 32'(tc_w), 32'd1);
    up = 1'b1;
    #1;
    checkOutput("live tc up", 32'(tc_w), 32'd0);

    // Bring both instances to 7, then reset between edges.
    @(negedge clk);
    load     = 1'b1;
    load_val = 4'd6;
    @(negedge clk);
    load = 1'b0;
    en   = 1'b1;
    up   = 1'b1;
    @(posedge clk);
    #1;
    checkAll("pre-reset", 4'd7, 4'b0100, 1'b0, 4'd7, 4'b0100, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkAll("async reset", 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0);
    @(posedge clk);
    #1;
    checkAll("reset held", 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      k4 = k[3:0];
      kg = k4 ^ (k4 >> 1);
      checkAll($sformatf("resume%0d", k), k4, kg, 1'b0, k4, kg, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
